// File: rtl/polygon_vertex_buffer_pkg.sv
// Shared definitions for the polygon vertex buffer: coordinate width and FSM states.
package polygon_vertex_buffer_pkg;

    // Width of one signed vertex coordinate in pixel units.
    localparam int COORD_W = 32;

    // Load-side controller states.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        PENDING = 2'd1,
        DROP    = 2'd2
    } state_t;

endpackage

// File: rtl/polygon_vertex_buffer.sv
// Double-buffered polygon vertex store. A vertex stream fills the back bank.
// A completed set waits in the back bank until the next frame start, when it is
// copied into the front bank. The front bank feeds the point-in-polygon tester.
module polygon_vertex_buffer
    import polygon_vertex_buffer_pkg::*;
#(
    parameter int MAX_NUM_VERTICES = 4
)
(
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      vertex_valid_in,
    input  logic signed [COORD_W-1:0] vertex_x_in,
    input  logic signed [COORD_W-1:0] vertex_y_in,
    input  logic                      vertex_last_in,
    output logic                      vertex_ready_out,
    input  logic                      new_frame_in,
    output logic signed [COORD_W-1:0] xs_out [MAX_NUM_VERTICES],
    output logic signed [COORD_W-1:0] ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0] num_vertices_out,
    output logic                      polygon_valid_out,
    output logic                      overflow_out
);

    localparam int CW = $clog2(MAX_NUM_VERTICES + 1);
    localparam int IW = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_NUM_VERTICES);

    state_t state;
    state_t next_state;

    logic [CW-1:0] wr_idx;
    logic [CW-1:0] back_count;
    logic signed [COORD_W-1:0] back_x [MAX_NUM_VERTICES];
    logic signed [COORD_W-1:0] back_y [MAX_NUM_VERTICES];

    logic handshake;
    logic slot_free;
    logic accept_vertex;
    logic overflow_hit;
    logic swap;
    logic [IW-1:0] wr_slot;
    logic [IW-1:0] src_idx [MAX_NUM_VERTICES];

    assign handshake     = vertex_valid_in && vertex_ready_out;
    assign slot_free     = (wr_idx < MAX_COUNT);
    assign accept_vertex = (state == LOAD) && handshake && slot_free;
    assign overflow_hit  = ((state == LOAD) && handshake && !slot_free && vertex_last_in) ||
                           ((state == DROP) && handshake && vertex_last_in);
    assign swap          = (state == PENDING) && new_frame_in;
    assign wr_slot       = IW'(wr_idx);

    // State register; reset returns the controller to LOAD.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode from the vertex handshake and the frame-start pulse.
    always_comb begin
        next_state = state;
        case (state)
            LOAD: begin
                if (handshake) begin
                    if (slot_free) begin
                        if (vertex_last_in) begin
                            next_state = PENDING;
                        end
                    end else if (!vertex_last_in) begin
                        next_state = DROP;
                    end
                end
            end
            PENDING: begin
                if (new_frame_in) begin
                    next_state = LOAD;
                end
            end
            DROP: begin
                if (handshake && vertex_last_in) begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = LOAD;
            end
        endcase
    end

    // Ready is held low while a completed set waits for its swap, and during reset.
    always_comb begin
        vertex_ready_out = 1'b0;
        if (!rst_in && (state != PENDING)) begin
            vertex_ready_out = 1'b1;
        end
    end

    // Front-bank source index: unused slots repeat the last vertex so they form zero-length edges.
    always_comb begin
        for (int k = 0; k < MAX_NUM_VERTICES; k++) begin
            src_idx[k] = '0;
            if (CW'(k) < back_count) begin
                src_idx[k] = IW'(k);
            end else begin
                src_idx[k] = IW'(back_count - CW'(1));
            end
        end
    end

    // Back-bank writes, write index, overflow pulse and the registered front-bank swap.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_idx            <= '0;
            back_count        <= '0;
            num_vertices_out  <= '0;
            polygon_valid_out <= 1'b0;
            overflow_out      <= 1'b0;
            for (int k = 0; k < MAX_NUM_VERTICES; k++) begin
                back_x[k] <= '0;
                back_y[k] <= '0;
                xs_out[k] <= '0;
                ys_out[k] <= '0;
            end
        end else begin
            overflow_out <= overflow_hit;

            if (accept_vertex) begin
                back_x[wr_slot] <= vertex_x_in;
                back_y[wr_slot] <= vertex_y_in;
                wr_idx          <= wr_idx + CW'(1);
                if (vertex_last_in) begin
                    back_count <= wr_idx + CW'(1);
                end
            end else if (overflow_hit) begin
                wr_idx <= '0;
            end

            if (swap) begin
                for (int k = 0; k < MAX_NUM_VERTICES; k++) begin
                    xs_out[k] <= back_x[src_idx[k]];
                    ys_out[k] <= back_y[src_idx[k]];
                end
                num_vertices_out  <= back_count;
                polygon_valid_out <= 1'b1;
                wr_idx            <= '0;
            end
        end
    end

endmodule

// File: tb/tb_polygon_vertex_buffer.sv
// Directed testbench for polygon_vertex_buffer with MAX_NUM_VERTICES = 4.
module tb_polygon_vertex_buffer;

    logic               clk_in;
    logic               rst_in;
    logic               vertex_valid_in;
    logic signed [31:0] vertex_x_in;
    logic signed [31:0] vertex_y_in;
    logic               vertex_last_in;
    logic               vertex_ready_out;
    logic               new_frame_in;
    logic signed [31:0] xs_out [4];
    logic signed [31:0] ys_out [4];
    logic [2:0]         num_vertices_out;
    logic               polygon_valid_out;
    logic               overflow_out;

    int errors = 0;
    int checks = 0;

    polygon_vertex_buffer #(.MAX_NUM_VERTICES(4)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .vertex_valid_in   (vertex_valid_in),
        .vertex_x_in       (vertex_x_in),
        .vertex_y_in       (vertex_y_in),
        .vertex_last_in    (vertex_last_in),
        .vertex_ready_out  (vertex_ready_out),
        .new_frame_in      (new_frame_in),
        .xs_out            (xs_out),
        .ys_out            (ys_out),
        .num_vertices_out  (num_vertices_out),
        .polygon_valid_out (polygon_valid_out),
        .overflow_out      (overflow_out)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic applyStimulus(input logic valid, input int x, input int y,
                                 input logic last, input logic nf, input logic rst);
        vertex_valid_in = valid;
        vertex_x_in     = x;
        vertex_y_in     = y;
        vertex_last_in  = last;
        new_frame_in    = nf;
        rst_in          = rst;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                               input logic signed [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkFront(input string tag, input int x0, input int x1, input int x2,
                              input int x3, input int y0, input int y1, input int y2,
                              input int y3);
        int ex [4];
        int ey [4];
        ex = '{x0, x1, x2, x3};
        ey = '{y0, y1, y2, y3};
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s.xs[%0d]", tag, k), xs_out[k], ex[k]);
            checkOutput($sformatf("%s.ys[%0d]", tag, k), ys_out[k], ey[k]);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        vertex_valid_in = 1'b0;
        vertex_x_in     = 0;
        vertex_y_in     = 0;
        vertex_last_in  = 1'b0;
        new_frame_in    = 1'b0;
        rst_in          = 1'b1;

        // Reset state, with a vertex and frame pulse offered during reset.
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 9, 9, 1'b1, 1'b1, 1'b1);
        checkOutput("rst.ready", vertex_ready_out, 0);
        checkOutput("rst.num", num_vertices_out, 0);
        checkOutput("rst.valid", polygon_valid_out, 0);
        checkOutput("rst.overflow", overflow_out, 0);
        checkFront("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        checkOutput("rst.release.ready", vertex_ready_out, 1);

        // Square, four vertices, last on the fourth.
        applyStimulus(1'b1, 10, 10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 50, 10, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 50, 40, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 10, 40, 1'b1, 1'b0, 1'b0);
        checkOutput("square.pending.ready", vertex_ready_out, 0);
        checkOutput("square.preswap.valid", polygon_valid_out, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkFront("square", 10, 50, 50, 10, 10, 10, 40, 40);
        checkOutput("square.num", num_vertices_out, 4);
        checkOutput("square.valid", polygon_valid_out, 1);
        checkOutput("square.ready", vertex_ready_out, 1);

        // Triangle padded with its last vertex; front holds the square until swap.
        applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 100, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 0, 100, 1'b1, 1'b0, 1'b0);
        checkFront("tri.hold", 10, 50, 50, 10, 10, 10, 40, 40);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkFront("tri", 0, 100, 0, 0, 0, 0, 100, 100);
        checkOutput("tri.num", num_vertices_out, 3);
        checkOutput("tri.overflow", overflow_out, 0);

        // Six vertices, last on the sixth: dropped with a single overflow pulse.
        applyStimulus(1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 3, 3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4, 4, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5, 5, 1'b0, 1'b0, 1'b0);
        checkOutput("six.drop.overflow", overflow_out, 0);
        checkOutput("six.drop.ready", vertex_ready_out, 1);
        applyStimulus(1'b1, 6, 6, 1'b1, 1'b0, 1'b0);
        checkOutput("six.overflow", overflow_out, 1);
        checkOutput("six.ready", vertex_ready_out, 1);
        idle();
        checkOutput("six.overflow.clear", overflow_out, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkFront("six.noswap", 0, 100, 0, 0, 0, 0, 100, 100);
        checkOutput("six.noswap.num", num_vertices_out, 3);
        checkOutput("six.after.ready", vertex_ready_out, 1);

        // Five vertices, last on the fifth: overflow straight from LOAD.
        applyStimulus(1'b1, 21, 21, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 22, 22, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 23, 23, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 24, 24, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 25, 25, 1'b1, 1'b0, 1'b0);
        checkOutput("five.overflow", overflow_out, 1);
        checkOutput("five.ready", vertex_ready_out, 1);
        idle();
        checkOutput("five.overflow.clear", overflow_out, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkFront("five.noswap", 0, 100, 0, 0, 0, 0, 100, 100);

        // Last handshake coincides with the frame pulse: no swap until the next pulse.
        applyStimulus(1'b1, -5, 7, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 20, 30, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 40, -60, 1'b1, 1'b1, 1'b0);
        checkFront("coinc.hold", 0, 100, 0, 0, 0, 0, 100, 100);
        checkOutput("coinc.num", num_vertices_out, 3);
        checkOutput("coinc.ready", vertex_ready_out, 0);
        applyStimulus(1'b1, 999, 999, 1'b1, 1'b0, 1'b0);
        checkOutput("pending.offer.ready", vertex_ready_out, 0);
        checkOutput("pending.offer.overflow", overflow_out, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkFront("coinc.swap", -5, 20, 40, 40, 7, 30, -60, -60);
        checkOutput("coinc.swap.num", num_vertices_out, 3);
        checkOutput("coinc.swap.ready", vertex_ready_out, 1);

        // Single vertex fills every slot.
        applyStimulus(1'b1, 7, 8, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkFront("single", 7, 7, 7, 7, 8, 8, 8, 8);
        checkOutput("single.num", num_vertices_out, 1);

        // Reset mid-load with a coincident last handshake and frame pulse.
        applyStimulus(1'b1, 11, 12, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 13, 14, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 15, 16, 1'b1, 1'b1, 1'b1);
        checkOutput("midrst.ready", vertex_ready_out, 0);
        checkOutput("midrst.num", num_vertices_out, 0);
        checkOutput("midrst.valid", polygon_valid_out, 0);
        checkOutput("midrst.overflow", overflow_out, 0);
        checkFront("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        checkOutput("midrst.release.ready", vertex_ready_out, 1);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("midrst.nf.valid", polygon_valid_out, 0);
        applyStimulus(1'b1, 3, 4, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkFront("midrst.reload", 3, 3, 3, 3, 4, 4, 4, 4);
        checkOutput("midrst.reload.num", num_vertices_out, 1);

        // Reset while a set is pending discards it.
        applyStimulus(1'b1, 1, 2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        idle();
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        checkOutput("pendrst.valid", polygon_valid_out, 0);
        checkOutput("pendrst.num", num_vertices_out, 0);
        checkOutput("pendrst.ready", vertex_ready_out, 1);

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
